// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/apb_arb_rr.sv
// Two-way round-robin pick: a lone eligible requester wins, a tie goes to the
// requester that was not granted last.
module apb_arb_rr (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |eligible;
    if (&eligible) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = eligible[1];
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Arbitrates two simple requesters onto one APB master port with round-robin
// grant, registered APB outputs, per-requester completion and an access timeout.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  PClk,
  input  logic                  PRESET,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned   CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  arb_state_t                 state_q, state_d;
  logic [CW-1:0]              wait_q, wait_d;
  logic                       gidx_q, gidx_d;
  logic                       last_q, last_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [1:0]                 done_q, done_d;
  logic [1:0]                 err_q, err_d;
  logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                 eligible;
  logic                       grant_valid, grant_idx, timed_out;

  // A requester whose done is high this cycle is finishing, not asking again.
  assign eligible  = {m1_req & ~done_q[1], m0_req & ~done_q[0]};
  assign timed_out = (wait_q == WAIT_LAST) && !PREADY;

  apb_arb_rr u_rr (
    .eligible    (eligible),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge PClk) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      gidx_q    <= 1'b0;
      last_q    <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || timed_out) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Computes the next value of every registered output so the APB and
  // requester-facing signals all come straight from flops.
  always_comb begin
    wait_d    = wait_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          gidx_d    = grant_idx;
          last_d    = grant_idx;
          paddr_d   = grant_idx ? m1_addr  : m0_addr;
          pwrite_d  = grant_idx ? m1_write : m0_write;
          pwdata_d  = grant_idx ? m1_wdata : m0_wdata;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          done_d[gidx_q]  = 1'b1;
          rdata_d[gidx_q] = PRDATA;
          err_d[gidx_q]   = PSLVERR;
        end else if (timed_out) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          done_d[gidx_q]  = 1'b1;
          rdata_d[gidx_q] = '0;
          err_d[gidx_q]   = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-age reference model.
module tb_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PClk = 1'b0;
  logic          PRESET = 1'b1;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic          m0_write = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_done, m1_done, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0, PSLVERR = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 PClk = ~PClk;

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PClk(PClk), .PRESET(PRESET),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Reference: a transfer is tracked by its age since grant (1 = setup,
  // 2.. = access number age-1); it ends on PREADY or after TO access cycles.
  logic          md_busy;
  int            md_age;
  logic          md_owner, md_last;
  logic [1:0]    md_done, md_err;
  logic [DW-1:0] md_rdata [2];
  logic [AW-1:0] md_paddr;
  logic          md_pwrite;
  logic [DW-1:0] md_pwdata;

  always @(posedge PClk) begin : ref_model
    bit e0, e1, pick;
    if (PRESET) begin
      md_busy <= 1'b0; md_age <= 0; md_owner <= 1'b0; md_last <= 1'b1;
      md_done <= 2'b00; md_err <= 2'b00; md_rdata[0] <= '0; md_rdata[1] <= '0;
      md_paddr <= '0; md_pwrite <= 1'b0; md_pwdata <= '0;
    end else begin
      md_done <= 2'b00;
      if (!md_busy) begin
        e0 = m0_req && !md_done[0];
        e1 = m1_req && !md_done[1];
        if (e0 || e1) begin
          pick = (e0 && e1) ? !md_last : e1;
          md_busy <= 1'b1; md_age <= 1; md_owner <= pick; md_last <= pick;
          md_paddr  <= pick ? m1_addr  : m0_addr;
          md_pwrite <= pick ? m1_write : m0_write;
          md_pwdata <= pick ? m1_wdata : m0_wdata;
        end
      end else if (md_age == 1) begin
        md_age <= 2;
      end else if (PREADY || (md_age - 1) == TO) begin
        md_busy <= 1'b0;
        md_age  <= 0;
        md_done[md_owner]  <= 1'b1;
        md_rdata[md_owner] <= PREADY ? PRDATA : '0;
        md_err[md_owner]   <= PREADY ? PSLVERR : 1'b1;
      end else begin
        md_age <= md_age + 1;
      end
    end
  end

  task automatic tick;
    @(posedge PClk);
    #1;
  endtask

  task automatic do_reset;
    PRESET = 1'b1; m0_req = 1'b0; m1_req = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick; tick;
    PRESET = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_vec++; if (PSEL !== 1'b0)     begin n_err++; $display("FAIL rst_psel got=%0h exp=0", PSEL); end
    n_vec++; if (PENABLE !== 1'b0)  begin n_err++; $display("FAIL rst_penable got=%0h exp=0", PENABLE); end
    n_vec++; if (PWRITE !== 1'b0)   begin n_err++; $display("FAIL rst_pwrite got=%0h exp=0", PWRITE); end
    n_vec++; if (PADDR !== '0)      begin n_err++; $display("FAIL rst_paddr got=%0h exp=0", PADDR); end
    n_vec++; if (PWDATA !== '0)     begin n_err++; $display("FAIL rst_pwdata got=%0h exp=0", PWDATA); end
    n_vec++; if (m0_done !== 1'b0)  begin n_err++; $display("FAIL rst_m0_done got=%0h exp=0", m0_done); end
    n_vec++; if (m1_done !== 1'b0)  begin n_err++; $display("FAIL rst_m1_done got=%0h exp=0", m1_done); end
    n_vec++; if (m0_rdata !== '0)   begin n_err++; $display("FAIL rst_m0_rdata got=%0h exp=0", m0_rdata); end
    n_vec++; if (m1_rdata !== '0)   begin n_err++; $display("FAIL rst_m1_rdata got=%0h exp=0", m1_rdata); end
    n_vec++; if (m0_err !== 1'b0)   begin n_err++; $display("FAIL rst_m0_err got=%0h exp=0", m0_err); end
    n_vec++; if (m1_err !== 1'b0)   begin n_err++; $display("FAIL rst_m1_err got=%0h exp=0", m1_err); end
  endtask

  task automatic test_single_write;
    do_reset;
    PREADY = 1'b1;
    m0_addr = 32'h10; m0_write = 1'b1; m0_wdata = 32'hA5A5A5A5; m0_req = 1'b1;
    tick;
    n_vec++; if (PSEL !== 1'b1)    begin n_err++; $display("FAIL wr_setup_psel got=%0h exp=1", PSEL); end
    n_vec++; if (PENABLE !== 1'b0) begin n_err++; $display("FAIL wr_setup_penable got=%0h exp=0", PENABLE); end
    n_vec++; if (PADDR !== 32'h10) begin n_err++; $display("FAIL wr_paddr got=%0h exp=10", PADDR); end
    n_vec++; if (PWRITE !== 1'b1)  begin n_err++; $display("FAIL wr_pwrite got=%0h exp=1", PWRITE); end
    n_vec++; if (PWDATA !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wr_pwdata got=%0h exp=a5a5a5a5", PWDATA); end
    tick;
    n_vec++; if (PENABLE !== 1'b1 || PSEL !== 1'b1) begin n_err++; $display("FAIL wr_access got=%0h%0h exp=11", PSEL, PENABLE); end
    tick;
    n_vec++; if (m0_done !== 1'b1) begin n_err++; $display("FAIL wr_done got=%0h exp=1", m0_done); end
    n_vec++; if (m0_err !== 1'b0)  begin n_err++; $display("FAIL wr_err got=%0h exp=0", m0_err); end
    n_vec++; if (PSEL !== 1'b0)    begin n_err++; $display("FAIL wr_psel_end got=%0h exp=0", PSEL); end
    m0_req = 1'b0;
    tick;
    n_vec++; if (m0_done !== 1'b0) begin n_err++; $display("FAIL wr_done_pulse got=%0h exp=0", m0_done); end
  endtask

  task automatic test_read_wait;
    int dcount = 0;
    int dcyc = -1;
    do_reset;
    m1_addr = 32'h20; m1_write = 1'b0; m1_wdata = '0; m1_req = 1'b1;
    PREADY = 1'b0; PRDATA = 32'h12345678;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (k <= 5) begin
        n_vec++; if (PSEL !== 1'b1 || PADDR !== 32'h20) begin
          n_err++; $display("FAIL rd_paddr_hold cyc=%0d got=%0h/%0h exp=1/20", k, PSEL, PADDR);
        end
      end
      if (m0_done) begin n_vec++; n_err++; $display("FAIL rd_wrong_done cyc=%0d got=1 exp=0", k); end
      if (m1_done) begin
        dcount++; dcyc = k; m1_req = 1'b0;
        n_vec++; if (m1_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata got=%0h exp=12345678", m1_rdata); end
        n_vec++; if (m1_err !== 1'b0) begin n_err++; $display("FAIL rd_err got=%0h exp=0", m1_err); end
      end
      PREADY = (k >= 5);
    end
    n_vec++; if (dcount !== 1) begin n_err++; $display("FAIL rd_done_count got=%0d exp=1", dcount); end
    n_vec++; if (dcyc !== 6)   begin n_err++; $display("FAIL rd_done_cycle got=%0d exp=6", dcyc); end
  endtask

  task automatic test_contention;
    int gcyc[4];
    int gown[4];
    int ng = 0;
    do_reset;
    for (int i = 0; i < 4; i++) begin gcyc[i] = -1; gown[i] = 9; end
    PREADY = 1'b1;
    m0_addr = 32'h100; m0_write = 1'b1; m0_wdata = $urandom;
    m1_addr = 32'h200; m1_write = 1'b0; m1_wdata = $urandom;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (PSEL && !PENABLE && ng < 4) begin
        gcyc[ng] = k;
        gown[ng] = (PADDR == 32'h100) ? 0 : ((PADDR == 32'h200) ? 1 : 8);
        ng++;
      end
      n_vec++; if ((m0_done & m1_done) !== 1'b0) begin n_err++; $display("FAIL cont_both_done cyc=%0d got=1 exp=0", k); end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (gown[i] !== (i % 2)) begin n_err++; $display("FAIL cont_order idx=%0d got=%0d exp=%0d", i, gown[i], i % 2); end
      n_vec++; if (gcyc[i] !== 1 + 3 * i) begin n_err++; $display("FAIL cont_spacing idx=%0d got=%0d exp=%0d", i, gcyc[i], 1 + 3 * i); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_timeout;
    bit seen = 1'b0;
    int acc = 0;
    logic t_err = 1'b0, t_psel = 1'b1;
    logic [DW-1:0] t_rdata = '1;
    PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
    m0_addr = 32'h30; m0_write = 1'b0; m0_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (m0_done) begin seen = 1'b1; break; end
    end
    m0_req = 1'b0;
    n_vec++; if (!seen || m0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL to_pre_read got=%0h exp=deadbeef", m0_rdata); end
    tick;
    seen = 1'b0;
    PREADY = 1'b0; m0_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (PENABLE) acc++;
      if (m0_done) begin
        seen = 1'b1; t_err = m0_err; t_rdata = m0_rdata; t_psel = PSEL; m0_req = 1'b0;
        break;
      end
    end
    m0_req = 1'b0;
    n_vec++; if (!seen)           begin n_err++; $display("FAIL to_done got=0 exp=1"); end
    n_vec++; if (acc !== TO)      begin n_err++; $display("FAIL to_access_cycles got=%0d exp=%0d", acc, TO); end
    n_vec++; if (t_err !== 1'b1)  begin n_err++; $display("FAIL to_err got=%0h exp=1", t_err); end
    n_vec++; if (t_rdata !== '0)  begin n_err++; $display("FAIL to_rdata got=%0h exp=0", t_rdata); end
    n_vec++; if (t_psel !== 1'b0) begin n_err++; $display("FAIL to_psel got=%0h exp=0", t_psel); end
    PREADY = 1'b1;
    tick;
  endtask

  task automatic test_slverr;
    bit seen = 1'b0;
    PREADY = 1'b1; PSLVERR = 1'b1;
    m0_addr = 32'h44; m0_write = 1'b1; m0_wdata = 32'h5A5A0F0F; m0_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (m0_done) begin
        seen = 1'b1; m0_req = 1'b0;
        n_vec++; if (m0_err !== 1'b1) begin n_err++; $display("FAIL slverr_err got=%0h exp=1", m0_err); end
        break;
      end
    end
    m0_req = 1'b0; PSLVERR = 1'b0;
    n_vec++; if (!seen) begin n_err++; $display("FAIL slverr_done got=0 exp=1"); end
    tick;
  endtask

  task automatic test_reset_mid;
    int dcount = 0;
    do_reset;
    PREADY = 1'b0;
    m0_addr = 32'h40; m0_write = 1'b0; m0_req = 1'b1;
    tick; tick;
    n_vec++; if (PENABLE !== 1'b1) begin n_err++; $display("FAIL rmid_in_access got=%0h exp=1", PENABLE); end
    PRESET = 1'b1; m0_req = 1'b0;
    tick;
    PRESET = 1'b0;
    n_vec++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_err++; $display("FAIL rmid_abort got=%0h%0h exp=00", PSEL, PENABLE); end
    if (m0_done) dcount++;
    PREADY = 1'b1;
    repeat (10) begin tick; if (m0_done || m1_done) dcount++; end
    n_vec++; if (dcount !== 0) begin n_err++; $display("FAIL rmid_no_done got=%0d exp=0", dcount); end
    m0_addr = 32'h100; m1_addr = 32'h200; m0_req = 1'b1; m1_req = 1'b1;
    tick;
    n_vec++; if (PSEL !== 1'b1 || PADDR !== 32'h100) begin n_err++; $display("FAIL rmid_tie_m0 got=%0h/%0h exp=1/100", PSEL, PADDR); end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) tick;
  endtask

  task automatic rand_req(input logic req_i, input logic done_i,
                          output logic req_o, output logic [AW-1:0] addr_o,
                          output logic write_o, output logic [DW-1:0] wdata_o,
                          input logic [AW-1:0] addr_i, input logic write_i,
                          input logic [DW-1:0] wdata_i);
    req_o = req_i; addr_o = addr_i; write_o = write_i; wdata_o = wdata_i;
    if ((!req_i && $urandom_range(3) == 0) || (req_i && done_i && $urandom_range(1) == 0)) begin
      req_o = 1'b1; addr_o = $urandom; write_o = 1'($urandom_range(1)); wdata_o = $urandom;
    end else if (req_i && done_i) begin
      req_o = 1'b0;
    end else if (req_i && $urandom_range(49) == 0) begin
      req_o = 1'b0;
    end
  endtask

  task automatic test_random;
    logic          r;
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    do_reset;
    for (int c = 0; c < 900; c++) begin
      tick;
      n_vec++; if (PSEL !== md_busy) begin n_err++; $display("FAIL rnd_psel cyc=%0d got=%0h exp=%0h", c, PSEL, md_busy); end
      n_vec++; if (PENABLE !== (md_busy && md_age >= 2)) begin n_err++; $display("FAIL rnd_penable cyc=%0d got=%0h exp=%0h", c, PENABLE, md_busy && md_age >= 2); end
      n_vec++; if (PADDR !== md_paddr)   begin n_err++; $display("FAIL rnd_paddr cyc=%0d got=%0h exp=%0h", c, PADDR, md_paddr); end
      n_vec++; if (PWRITE !== md_pwrite) begin n_err++; $display("FAIL rnd_pwrite cyc=%0d got=%0h exp=%0h", c, PWRITE, md_pwrite); end
      n_vec++; if (PWDATA !== md_pwdata) begin n_err++; $display("FAIL rnd_pwdata cyc=%0d got=%0h exp=%0h", c, PWDATA, md_pwdata); end
      n_vec++; if (m0_done !== md_done[0]) begin n_err++; $display("FAIL rnd_m0_done cyc=%0d got=%0h exp=%0h", c, m0_done, md_done[0]); end
      n_vec++; if (m1_done !== md_done[1]) begin n_err++; $display("FAIL rnd_m1_done cyc=%0d got=%0h exp=%0h", c, m1_done, md_done[1]); end
      n_vec++; if (m0_rdata !== md_rdata[0]) begin n_err++; $display("FAIL rnd_m0_rdata cyc=%0d got=%0h exp=%0h", c, m0_rdata, md_rdata[0]); end
      n_vec++; if (m1_rdata !== md_rdata[1]) begin n_err++; $display("FAIL rnd_m1_rdata cyc=%0d got=%0h exp=%0h", c, m1_rdata, md_rdata[1]); end
      n_vec++; if (m0_err !== md_err[0]) begin n_err++; $display("FAIL rnd_m0_err cyc=%0d got=%0h exp=%0h", c, m0_err, md_err[0]); end
      n_vec++; if (m1_err !== md_err[1]) begin n_err++; $display("FAIL rnd_m1_err cyc=%0d got=%0h exp=%0h", c, m1_err, md_err[1]); end
      n_vec++; if ((m0_done & m1_done) !== 1'b0) begin n_err++; $display("FAIL rnd_both_done cyc=%0d got=1 exp=0", c); end
      if (PRESET) PRESET = 1'b0;
      else if ($urandom_range(99) == 0) PRESET = 1'b1;
      PREADY  = (c < 500) ? ($urandom_range(9) < 6) : ($urandom_range(19) == 0);
      PSLVERR = ($urandom_range(7) == 0);
      PRDATA  = $urandom;
      rand_req(m0_req, m0_done, r, a, w, d, m0_addr, m0_write, m0_wdata);
      m0_req = r; m0_addr = a; m0_write = w; m0_wdata = d;
      rand_req(m1_req, m1_done, r, a, w, d, m1_addr, m1_write, m1_wdata);
      m1_req = r; m1_addr = a; m1_write = w; m1_wdata = d;
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_wait;
    test_contention;
    test_timeout;
    test_slverr;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of requester and APB address buses.
REQ-002 Parameter DATA_WIDTH, default 32, data width of write and read buses.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles allowed before a transfer is aborted.
REQ-004 The block SHALL have one clock, PClk; reset PRESET is synchronous and active-high.
REQ-005 Ports, one per line:
- PClk  in  1  clock
- PRESET  in  1  synchronous active-high reset
- mN_req  in  1  transfer request from requester N (N = 0, 1)
- mN_addr  in  ADDR_WIDTH  requester N address
- mN_write  in  1  requester N direction, 1 = write
- mN_wdata  in  DATA_WIDTH  requester N write data
- mN_done  out  1  one-cycle completion pulse to requester N
- mN_rdata  out  DATA_WIDTH  read data, valid while mN_done = 1
- mN_err  out  1  error flag, valid while mN_done = 1
- PSEL, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1  APB ready and slave error

Function
REQ-006 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-007 In IDLE, a requester is eligible if its req = 1 and its done = 0 in that cycle.
REQ-008 With one eligible requester, the arbiter SHALL grant it; with both eligible, it SHALL grant the requester not granted last (round-robin).
REQ-009 On a grant, the next edge SHALL enter SETUP with PSEL = 1 and PENABLE = 0, and SHALL register PADDR, PWRITE and PWDATA from the granted requester.
REQ-010 The transition SETUP -> ACCESS SHALL be unconditional and raise PENABLE = 1.
REQ-011 All APB outputs SHALL be register-driven and held stable from SETUP through the end of ACCESS.
REQ-012 In ACCESS, when PREADY = 1 the next edge SHALL:
- enter IDLE with PSEL = 0 and PENABLE = 0;
- pulse mN_done of the granted requester for exactly one cycle;
- latch PRDATA into mN_rdata and PSLVERR into mN_err.
REQ-013 A wait counter SHALL reset to 0 on entering ACCESS and increment each ACCESS cycle with PREADY = 0.
REQ-014 If the wait counter reaches TIMEOUT-1 with PREADY = 0, the next edge SHALL enter IDLE, pulse done with err = 1 and rdata = 0, and deassert PSEL.
REQ-015 The requester SHALL hold mN_addr, mN_write and mN_wdata stable from req until done; the arbiter samples them only on the grant edge.
REQ-016 If req stays high after done, the arbiter SHALL treat it as a new request from the following IDLE cycle.
REQ-017 Req to PSEL latency SHALL be 1 cycle; minimum req to done latency SHALL be 3 cycles; a back-to-back transfer to the same or the other requester SHALL cost one IDLE cycle.
REQ-018 A requester that drops req before done SHALL NOT cancel an in-flight transfer; done is still pulsed.
REQ-019 mN_rdata and mN_err SHALL hold their last value when done = 0; they are only guaranteed valid while done = 1.
REQ-020 Both done outputs SHALL never be high in the same cycle.

Reset
REQ-021 On PRESET = 1 at a clock edge, the block SHALL set: state = IDLE, PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, both done = 0, both rdata = 0, both err = 0, wait counter = 0, last-grant = 1 (so m0 wins the first tie).
REQ-022 A reset during SETUP or ACCESS SHALL abort the transfer without pulsing done.

Structure
REQ-023 The shared package apb_arb_pkg SHALL hold the state enumeration and the default TIMEOUT constant.
REQ-024 The round-robin selection SHALL be a sub-module, apb_arb_rr, with inputs eligible[1:0] and last_grant, and outputs grant_valid and grant_idx.

Verification
REQ-025 Single write: m0 writes addr 0x10, data 0xA5A5A5A5, PREADY tied 1 -> PSEL one cycle after req, PENABLE the next cycle, m0_done 3 cycles after req, m0_err = 0.
REQ-026 Read with wait states: m1 reads addr 0x20, PREADY low for 3 ACCESS cycles, PRDATA = 0x12345678 -> m1_done once, m1_rdata = 0x12345678, PADDR stable throughout.
REQ-027 Contention: m0 and m1 request together from reset and both hold req -> grant order m0, m1, m0, m1, with one IDLE cycle between transfers.
REQ-028 Timeout: PREADY held 0 -> done with err = 1 after exactly 16 ACCESS cycles, then PSEL = 0.
REQ-029 Slave error: PSLVERR = 1 together with PREADY = 1 -> m0_err = 1 during m0_done.
REQ-030 Reset mid-ACCESS: PRESET pulsed for 1 cycle -> PSEL = 0 and PENABLE = 0 next cycle, no done pulse, next tie granted to m0.
